// File: rtl/mult_pkg.sv
// Shared types and default widths for the sequential Booth multiplier.
// Holds the controller state encoding used by the top-level FSM.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } state_t;

  localparam int A_BITS_DEF = 8;
  localparam int B_BITS_DEF = 8;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add/sub of M into ACC, then arithmetic shift of {ACC,Q,QM1}.
// Purely combinational, zero latency; no flow control.
module booth_step #(
  parameter int A_bits = 8,
  parameter int B_bits = 8
) (
  input  logic [A_bits:0]   acc,
  input  logic [B_bits-1:0] q,
  input  logic              qm1,
  input  logic [A_bits:0]   m,
  output logic [A_bits:0]   acc_nxt,
  output logic [B_bits-1:0] q_nxt,
  output logic              qm1_nxt
);

  logic [A_bits:0] sum;

  always_comb begin
    sum = acc;
    case ({q[0], qm1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
    // The bit leaving ACC enters the top of Q; ACC's sign is replicated.
    acc_nxt = {sum[A_bits], sum[A_bits:1]};
    q_nxt   = B_bits'({sum[0], q} >> 1);
    qm1_nxt = q[0];
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Sequential radix-2 Booth multiplier; S and END_MULT arrive B_bits edges after START is accepted.
// START is only sampled in IDLE; requests while busy are dropped, there is no other backpressure.
module booth_seq_multiplier
  import mult_pkg::*;
#(
  parameter int A_bits = A_BITS_DEF,
  parameter int B_bits = B_BITS_DEF
) (
  input  logic                     CLOCK,
  input  logic                     RESET,
  input  logic                     START,
  input  logic [A_bits-1:0]        A,
  input  logic [B_bits-1:0]        B,
  output logic [A_bits+B_bits-1:0] S,
  output logic                     END_MULT
);

  localparam int CW = $clog2(B_bits + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(B_bits - 1);

  state_t            state;
  logic [A_bits:0]   m;
  logic [A_bits:0]   acc;
  logic [B_bits-1:0] q;
  logic              qm1;
  logic [CW-1:0]     cnt;

  logic [A_bits:0]   acc_nxt;
  logic [B_bits-1:0] q_nxt;
  logic              qm1_nxt;

  booth_step #(
    .A_bits(A_bits),
    .B_bits(B_bits)
  ) u_step (
    .acc     (acc),
    .q       (q),
    .qm1     (qm1),
    .m       (m),
    .acc_nxt (acc_nxt),
    .q_nxt   (q_nxt),
    .qm1_nxt (qm1_nxt)
  );

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      m        <= '0;
      acc      <= '0;
      q        <= '0;
      qm1      <= 1'b0;
      cnt      <= '0;
      S        <= '0;
      END_MULT <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          END_MULT <= 1'b0;
          if (START) begin
            m     <= {A[A_bits-1], A};
            acc   <= '0;
            q     <= B;
            qm1   <= 1'b0;
            cnt   <= '0;
            state <= ITER;
          end
        end
        ITER: begin
          acc <= acc_nxt;
          q   <= q_nxt;
          qm1 <= qm1_nxt;
          cnt <= cnt + CW'(1);
          // The extra ACC bit is dropped: the product always fits A_bits+B_bits.
          if (cnt == LAST_STEP) begin
            S        <= {acc_nxt[A_bits-1:0], q_nxt};
            END_MULT <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          END_MULT <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          END_MULT <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Directed and randomized checks of the sequential Booth multiplier with 8x8 operands.
module tb_booth_seq_multiplier;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        START;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] S;
  logic        END_MULT;

  int n_cmp = 0;
  int n_err = 0;

  booth_seq_multiplier #(
    .A_bits(8),
    .B_bits(8)
  ) dut (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .START    (START),
    .A        (A),
    .B        (B),
    .S        (S),
    .END_MULT (END_MULT)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts edges after the current point until END_MULT is seen; -1 if the budget expires.
  task automatic wait_end(input int budget, output int lat);
    lat = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge CLOCK); #1;
      if (END_MULT === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                        input string tag, input bit disturb);
    int lat;
    @(negedge CLOCK);
    A = a; B = b; START = 1'b1;
    @(posedge CLOCK); #1;
    START = 1'b0;
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge CLOCK); #1;
      if (disturb && i == 3) begin
        START = 1'b1; A = 8'h64; B = 8'h9C;
      end
      if (disturb && i == 4) begin
        START = 1'b0; A = 8'h11; B = 8'h22;
      end
      if (END_MULT === 1'b1) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'd8);
    check({tag, " product"}, 32'(S), 32'(exp));
    @(posedge CLOCK); #1;
    check({tag, " pulse width"}, 32'(END_MULT), 32'd0);
    check({tag, " product hold"}, 32'(S), 32'(exp));
  endtask

  initial begin
    int lat;
    int seen;
    int p;
    logic signed [7:0] ra;
    logic signed [7:0] rb;

    RESET = 1'b1; START = 1'b0; A = '0; B = '0;
    #1;
    check("reset S", 32'(S), 32'd0);
    check("reset END_MULT", 32'(END_MULT), 32'd0);
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b0;

    run_op(8'd3,   8'd5,   16'h000F, "3*5",       1'b0);
    run_op(8'hFF,  8'd1,   16'hFFFF, "-1*1",      1'b0);
    run_op(8'd127, 8'h80,  16'hC080, "127*-128",  1'b0);
    run_op(8'h80,  8'h80,  16'h4000, "-128*-128", 1'b0);
    run_op(8'd0,   8'hB3,  16'h0000, "0*-77",     1'b0);
    run_op(8'd7,   8'hFD,  16'hFFEB, "7*-3 busy", 1'b1);

    // Abort an operation part-way through with an asynchronous reset.
    run_op(8'd3, 8'd5, 16'h000F, "pre-abort", 1'b0);
    @(negedge CLOCK);
    A = 8'd7; B = 8'd9; START = 1'b1;
    @(posedge CLOCK); #1;
    START = 1'b0;
    repeat (3) @(posedge CLOCK);
    #3 RESET = 1'b1;
    #1;
    check("abort S", 32'(S), 32'd0);
    check("abort END_MULT", 32'(END_MULT), 32'd0);
    repeat (2) @(posedge CLOCK);
    #1 RESET = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLOCK); #1;
      if (END_MULT === 1'b1) seen++;
    end
    check("abort no END_MULT", 32'(seen), 32'd0);
    check("abort S stays 0", 32'(S), 32'd0);

    // START held high: the second operation is accepted on the first IDLE edge after DONE.
    @(negedge CLOCK);
    A = 8'd5; B = 8'd6; START = 1'b1;
    @(posedge CLOCK); #1;
    A = 8'hF7; B = 8'h0B;
    wait_end(12, lat);
    check("held first latency", 32'(lat), 32'd8);
    check("held first product", 32'(S), 32'h001E);
    @(posedge CLOCK); #1;
    check("held first pulse width", 32'(END_MULT), 32'd0);
    @(posedge CLOCK); #1;
    START = 1'b0;
    wait_end(12, lat);
    check("held second latency", 32'(lat), 32'd8);
    check("held second product", 32'(S), 32'hFF9D);
    @(posedge CLOCK); #1;
    check("held second pulse width", 32'(END_MULT), 32'd0);

    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      p  = int'(ra) * int'(rb);
      run_op(ra, rb, p[15:0], "random", 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
